pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It drives the write-enable, hold and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses using a req/ready handshake with a timeout. Its state updates on the rising clock edge, so its outputs are stable before the pipeline registers capture on the falling edge.

Parameters:
REG_W, 5, register index width
MEM_TIMEOUT, 8, consecutive MEM_WAIT cycles with mem_ready low before the error state (must be >= 1)
CNT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  clock; state updates on rising edge
rst  in  1  asynchronous reset, active-high
id_rs1  in  REG_W  rs1 of the instruction in ID
id_rs2  in  REG_W  rs2 of the instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_W  destination register of the EX instruction
mem_req  in  1  MEM-stage instruction accesses data memory (load or store)
mem_ready  in  1  data memory has completed the access this cycle
branch_taken  in  1  MEM-stage branch/jump is taken (branch AND zero already combined)
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID update enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_hold  out  1  ID/EX keeps its contents
id_ex_flush  out  1  ID/EX loads a bubble (control fields zero)
ex_mem_hold  out  1  EX/MEM keeps its contents
ex_mem_flush  out  1  EX/MEM loads a bubble
mem_wb_bubble  out  1  MEM/WB loads a bubble
mem_timeout_err  out  1  sticky memory-timeout error
stall_count  out  CNT_W  number of cycles with pc_write=0, saturating

Behaviour:
- States: RUN, MEM_WAIT, ERR. Internal wait_cnt has width ceil(log2(MEM_TIMEOUT+1)).
- Reset (rst=1, async): state=RUN, wait_cnt=0, stall_count=0, mem_timeout_err=0.
  - While rst=1, all 1-bit control outputs are 0 (pc_write=0, if_id_write=0) and stall_count does not count.
- Outputs are combinational from state and current inputs. Defaults: pc_write=1, if_id_write=1, all holds, flushes and bubbles 0.
- load_use = ex_mem_read AND ex_rd!=0 AND (ex_rd==id_rs1 OR (id_uses_rs2 AND ex_rd==id_rs2)).
- mem_stall = mem_req AND NOT mem_ready.
- RUN, evaluated in priority order:
  1. mem_stall: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, mem_wb_bubble=1. Next state MEM_WAIT, wait_cnt<=0.
  2. branch_taken: pc_write=1 (PC takes the target), if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. Stay in RUN.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. One-cycle bubble; stay in RUN.
  4. Otherwise: defaults.
  - Branch beats load-use in the same cycle, because the wrong-path instruction is discarded anyway.
  - mem_req with mem_ready=1 in RUN causes no stall (single-cycle access).
- MEM_WAIT:
  - mem_ready=0: same outputs as RUN rule 1.
    - If wait_cnt==MEM_TIMEOUT-1: next state ERR, mem_timeout_err<=1.
    - Else wait_cnt<=wait_cnt+1.
  - mem_ready=1: outputs follow RUN rules 2-4 for this cycle (the access completes and the pipeline advances). Next state RUN, wait_cnt<=0.
  - branch_taken in MEM_WAIT is ignored until release.
- ERR: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, mem_wb_bubble=1. mem_timeout_err=1. Only rst exits ERR.
- stall_count: on each rising edge with rst=0 and pc_write=0, it increments. It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately (asynchronously) and clears the error and the counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for that cycle only; stall_count 0->1. Repeat with ex_rd=0 -> no stall.
- rs2 gating: ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall; id_uses_rs2=1 -> stall.
- Branch with simultaneous load-use: branch_taken=1 and load_use true -> pc_write=1, if_id_flush=id_ex_flush=ex_mem_flush=1, no stall; stall_count unchanged.
- Multi-cycle memory: mem_req=1, mem_ready low for 3 cycles then high (MEM_TIMEOUT=8) -> 3 stall cycles with all holds asserted. Defaults on the ready cycle, state back to RUN, stall_count=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> 1 RUN stall cycle plus 4 MEM_WAIT cycles. mem_timeout_err rises after the 5th rising edge and stays high with mem_ready=1; stall_count keeps incrementing.
- Async reset: assert rst mid-MEM_WAIT between clock edges -> all outputs 0 and stall_count=0 immediately. After release, state is RUN with default outputs.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline.
// Resolves load-use hazards, taken branches resolved in MEM, and multi-cycle
// data-memory accesses with a timeout. Outputs are combinational from the
// state and the current inputs, and are forced low while rst_i is high.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_RUN      | normal flow; load-use bubbles and branch flushes handled here
// S_MEM_WAIT | MEM-stage access outstanding; upstream frozen, MEM/WB bubbled
// S_ERR      | memory access timed out; pipeline frozen until reset
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_hold_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_bubble_o,
  output logic             mem_timeout_err_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  // Bundle of the eight pipeline-register controls, MSB first.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;
    logic ex_mem_hold;
    logic ex_mem_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{id_ex_hold: 1'b1, ex_mem_hold: 1'b1,
                                     mem_wb_bubble: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_BRANCH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                     id_ex_flush: 1'b1, ex_mem_flush: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_LOADUSE = '{id_ex_flush: 1'b1, default: 1'b0};

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic  load_use;
  logic  mem_stall;
  ctrl_t adv_ctrl;
  ctrl_t fsm_ctrl;
  ctrl_t ctrl;

  // Hazard detection; x0 is never a real dependency.
  always_comb begin
    load_use  = ex_mem_read_i && (ex_rd_i != '0) &&
                ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
    mem_stall = mem_req_i && !mem_ready_i;
  end

  // Controls when the pipeline is allowed to advance: branch beats load-use,
  // since the wrong-path instruction in ID is discarded anyway.
  always_comb begin
    adv_ctrl = CTRL_DEFAULT;
    if (branch_taken_i) begin
      adv_ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      adv_ctrl = CTRL_LOADUSE;
    end
  end

  // Next-state, wait-timer and control selection for the current state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    fsm_ctrl   = CTRL_DEFAULT;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          fsm_ctrl   = CTRL_FREEZE;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          fsm_ctrl = adv_ctrl;
        end
      end
      S_MEM_WAIT: begin
        // A branch_taken seen here is ignored until the access is released.
        if (!mem_ready_i) begin
          fsm_ctrl = CTRL_FREEZE;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          fsm_ctrl   = adv_ctrl;
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      S_ERR: begin
        fsm_ctrl = CTRL_FREEZE;
        err_d    = 1'b1;
      end
      default: begin
        fsm_ctrl   = CTRL_FREEZE;
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Everything is held low during reset so no register captures mid-reset.
  always_comb begin
    ctrl = rst_i ? ctrl_t'('0) : fsm_ctrl;
  end

  // Stall statistics: count cycles where the PC is held, saturating at max.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Controller state registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    pc_write_o        = ctrl.pc_write;
    if_id_write_o     = ctrl.if_id_write;
    if_id_flush_o     = ctrl.if_id_flush;
    id_ex_hold_o      = ctrl.id_ex_hold;
    id_ex_flush_o     = ctrl.id_ex_flush;
    ex_mem_hold_o     = ctrl.ex_mem_hold;
    ex_mem_flush_o    = ctrl.ex_mem_flush;
    mem_wb_bubble_o   = ctrl.mem_wb_bubble;
    mem_timeout_err_o = err_q && !rst_i;
    stall_count_o     = stall_cnt_q;
  end

endmodule
